etc_ctrl: RTL and testbench

Request/response front-end for the `etc` 4x4 matrix datapath. It accepts matrix operations on a valid/ready request stream and drives `etc` op/inA/inB with the required issue discipline, including the one-cycle hold that op 3 needs. It tracks in-flight operations through the fixed `etc` latency and captures every result beat into a response FIFO, so a backpressuring consumer never loses data.

---
 rtl/etc_pkg.sv | 26 ++
 rtl/etc_rsp_fifo.sv | 64 ++++++
 rtl/etc_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_etc_ctrl.sv | 305 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/etc_pkg.sv
// etc_pkg: shared definitions for the etc request/response front-end.
//   OP_HALF / OP_DUAL : op codes with special handling (half result, two beats)
//   mat_in_t / mat_out_t : 4x4 operand and result matrix types
//   issue_st_t        : issue FSM state encoding
//   beats(op)         : number of result beats an op produces
package etc_pkg;

   localparam int ETC_W = 12;

   localparam logic [3:0] OP_HALF = 4'd2;
   localparam logic [3:0] OP_DUAL = 4'd3;

   typedef logic [3:0][3:0][ETC_W-1:0]   mat_in_t;
   typedef logic [3:0][3:0][2*ETC_W-1:0] mat_out_t;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ISSUE = 2'd1,
      ST_HOLD  = 2'd2
   } issue_st_t;

   function automatic logic [1:0] beats(input logic [3:0] op);
      return (op == OP_DUAL) ? 2'd2 : 2'd1;
   endfunction

endpackage

// File: rtl/etc_rsp_fifo.sv
// etc_rsp_fifo: first-word-fall-through FIFO for response beats.
//   clk, rst        : clock, synchronous active-high reset (pointers/count only)
//   push, push_data : write one entry
//   pop             : drop the head entry (ignored when empty)
//   head            : current head entry, meaningful while count != 0
//   count           : number of stored entries
module etc_rsp_fifo #(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_pop;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
   endfunction

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   // storage carries data only, so it is never reset
   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= push_data;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         // the upstream credit scheme guarantees a free slot on every push
         assert (!(push && !do_pop && (count == CW'(DEPTH))))
            else $error("etc_rsp_fifo overflow");
         if (push) begin
            wr_ptr <= ptr_inc(wr_ptr);
         end
         if (do_pop) begin
            rd_ptr <= ptr_inc(rd_ptr);
         end
         case ({push, do_pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/etc_ctrl.sv
// etc_ctrl: request/response front-end for the etc 4x4 matrix datapath.
//   clk, rst                 : clock, synchronous active-high reset
//   req_valid/req_ready      : request handshake; req_op, req_a, req_b payload
//   etc_op, etc_inA, etc_inB : registered drive into etc
//   etc_out                  : etc result, sampled LATENCY edges after launch
//   rsp_valid/rsp_ready      : response handshake (FWFT FIFO head)
//   rsp_op, rsp_last, rsp_data : head beat; zero while rsp_valid is low
module etc_ctrl
   import etc_pkg::*;
#(
   parameter int W       = ETC_W,
   parameter int LATENCY = 2,
   parameter int DEPTH   = 4
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     req_valid,
   output logic                     req_ready,
   input  logic [3:0]               req_op,
   input  logic [3:0][3:0][W-1:0]   req_a,
   input  logic [3:0][3:0][W-1:0]   req_b,
   output logic [3:0]               etc_op,
   output logic [3:0][3:0][W-1:0]   etc_inA,
   output logic [3:0][3:0][W-1:0]   etc_inB,
   input  logic [3:0][3:0][2*W-1:0] etc_out,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [3:0]               rsp_op,
   output logic                     rsp_last,
   output logic [3:0][3:0][2*W-1:0] rsp_data
);

   localparam int CW = $clog2(DEPTH + 1);
   localparam int SW = CW + 2;
   localparam int FW = 5 + 32 * W;

   issue_st_t state;
   issue_st_t state_nxt;

   logic                     accept;
   logic [SW-1:0]            credit_need;
   logic [CW-1:0]            fifo_count;
   logic [CW-1:0]            inflight;

   logic                     issue_vld;
   logic                     issue_last;
   logic [3:0]               issue_op;

   logic [LATENCY-1:0]       vld_p;
   logic [LATENCY-1:0]       last_p;
   logic [LATENCY-1:0][3:0]  op_p;

   logic                     cap_push;
   logic [3:0][3:0][2*W-1:0] cap_data;

   logic [FW-1:0]            fifo_wdata;
   logic [FW-1:0]            fifo_head;
   logic [3:0]               head_op;
   logic                     head_last;
   logic [3:0][3:0][2*W-1:0] head_data;

   // A request is admitted only when every beat it will produce already has
   // a FIFO slot reserved; this is what lets the consumer stall freely.
   assign credit_need = SW'(fifo_count) + SW'(inflight) + SW'(beats(req_op));
   assign req_ready   = !rst && (state != ST_HOLD) && (credit_need <= SW'(DEPTH));
   assign accept      = req_valid && req_ready;

   // ST_HOLD marks the first cycle of an op-3 issue: the next edge re-launches
   // the same operands for the second beat, so no new request may be taken.
   // The cycle after that is an ordinary ISSUE cycle that can accept again,
   // giving one op 3 every two cycles.
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt  = ST_IDLE;
      issue_vld  = 1'b0;
      issue_last = 1'b1;
      issue_op   = etc_op;
      if (state == ST_HOLD) begin
         state_nxt = ST_ISSUE;
         issue_vld = 1'b1;
      end else if (accept) begin
         state_nxt  = (req_op == OP_DUAL) ? ST_HOLD : ST_ISSUE;
         issue_vld  = 1'b1;
         issue_last = (req_op != OP_DUAL);
         issue_op   = req_op;
      end
   end

   // ---- stage p0: launch onto etc ----
   always_ff @(posedge clk) begin
      if (rst) begin
         etc_op  <= '0;
         etc_inA <= '0;
         etc_inB <= '0;
      end else if (accept) begin
         etc_op  <= req_op;
         etc_inA <= req_a;
         etc_inB <= req_b;
      end else if (state != ST_HOLD) begin
         etc_op  <= '0;
         etc_inA <= '0;
         etc_inB <= '0;
      end
   end

   // ---- stages p0..p(LATENCY-1): beat tracking alongside etc ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p <= '0;
      end else begin
         vld_p[0] <= issue_vld;
         for (int i = 1; i < LATENCY; i++) begin
            vld_p[i] <= vld_p[i-1];
         end
      end
   end

   always_ff @(posedge clk) begin
      op_p[0]   <= issue_op;
      last_p[0] <= issue_last;
      for (int i = 1; i < LATENCY; i++) begin
         op_p[i]   <= op_p[i-1];
         last_p[i] <= last_p[i-1];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         inflight <= '0;
      end else begin
         inflight <= inflight
                   + (accept   ? CW'(beats(req_op)) : CW'(0))
                   - (cap_push ? CW'(1)             : CW'(0));
      end
   end

   // ---- capture: etc result into the response FIFO ----
   assign cap_push = vld_p[LATENCY-1];

   always_comb begin
      cap_data = etc_out;
      if (op_p[LATENCY-1] == OP_HALF) begin
         cap_data[2] = '0;
         cap_data[3] = '0;
      end
   end

   assign fifo_wdata = {op_p[LATENCY-1], last_p[LATENCY-1], cap_data};

   etc_rsp_fifo #(
      .WIDTH (FW),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (cap_push),
      .push_data (fifo_wdata),
      .pop       (rsp_valid && rsp_ready),
      .head      (fifo_head),
      .count     (fifo_count)
   );

   assign head_op   = fifo_head[FW-1 -: 4];
   assign head_last = fifo_head[FW-5];
   assign head_data = fifo_head[FW-6:0];

   // Unreset storage may hold stale beats, so the head is masked when empty.
   assign rsp_valid = (fifo_count != '0);
   assign rsp_op    = rsp_valid ? head_op   : 4'd0;
   assign rsp_last  = rsp_valid ? head_last : 1'b0;
   assign rsp_data  = rsp_valid ? head_data : '0;

endmodule

// File: tb/tb_etc_ctrl.sv
module tb_etc_ctrl;
   import etc_pkg::*;

   localparam int W       = 12;
   localparam int LATENCY = 2;
   localparam int DEPTH   = 4;

   logic       clk;
   logic       rst;
   logic       req_valid;
   logic       req_ready;
   logic [3:0] req_op;
   mat_in_t    req_a;
   mat_in_t    req_b;
   logic [3:0] etc_op;
   mat_in_t    etc_inA;
   mat_in_t    etc_inB;
   mat_out_t   etc_out;
   mat_out_t   etc_stage;
   logic       rsp_valid;
   logic       rsp_ready;
   logic [3:0] rsp_op;
   logic       rsp_last;
   mat_out_t   rsp_data;

   int errors;
   int checks;

   etc_ctrl #(
      .W       (W),
      .LATENCY (LATENCY),
      .DEPTH   (DEPTH)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_op    (req_op),
      .req_a     (req_a),
      .req_b     (req_b),
      .etc_op    (etc_op),
      .etc_inA   (etc_inA),
      .etc_inB   (etc_inB),
      .etc_out   (etc_out),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_op    (rsp_op),
      .rsp_last  (rsp_last),
      .rsp_data  (rsp_data)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Stand-in for etc: op 0 adds elementwise, other ops multiply matrices.
   // Op 2 drives junk in rows 2-3, which the controller must zero.
   function automatic mat_out_t etc_fn(input logic [3:0] op, input mat_in_t a, input mat_in_t b);
      mat_out_t   r;
      logic [23:0] acc;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            if (op == 4'd0) begin
               r[i][j] = 24'(a[i][j]) + 24'(b[i][j]);
            end else begin
               acc = '0;
               for (int k = 0; k < 4; k++) acc = acc + 24'(a[i][k]) * 24'(b[k][j]);
               r[i][j] = acc;
            end
         end
      end
      if (op == OP_HALF) begin
         for (int j = 0; j < 4; j++) begin
            r[2][j] = 24'hA5A5A5;
            r[3][j] = 24'h5A5A5A;
         end
      end
      return r;
   endfunction

   // LATENCY = 2: one register between launch and sampling edge
   always @(posedge clk) etc_stage <= etc_fn(etc_op, etc_inA, etc_inB);
   assign etc_out = etc_stage;

   function automatic mat_in_t fill_in(input logic [11:0] v);
      mat_in_t m;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = v;
      return m;
   endfunction

   function automatic mat_out_t fill_out(input logic [23:0] v);
      mat_out_t m;
      for (int i = 0; i < 4; i++) for (int j = 0; j < 4; j++) m[i][j] = v;
      return m;
   endfunction

   function automatic mat_in_t ident();
      mat_in_t m;
      m = '0;
      for (int i = 0; i < 4; i++) m[i][i] = 12'd1;
      return m;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; req_valid = 1'b1; req_op = 4'd1; req_a = ident(); req_b = fill_in(12'd5);
      rsp_ready = 1'b1;
      tick(); tick(); tick();
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rst_req_ready got %0b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL rst_rsp_valid got %0b want 0", rsp_valid); end
      checks++; if (rsp_op !== 4'd0) begin errors++; $display("FAIL rst_rsp_op got %0d want 0", rsp_op); end
      checks++; if (rsp_last !== 1'b0) begin errors++; $display("FAIL rst_rsp_last got %0b want 0", rsp_last); end
      checks++; if (rsp_data !== '0) begin errors++; $display("FAIL rst_rsp_data got %0h want 0", rsp_data); end
      checks++; if (etc_op !== 4'd0) begin errors++; $display("FAIL rst_etc_op got %0d want 0", etc_op); end
      checks++; if (etc_inA !== '0) begin errors++; $display("FAIL rst_etc_inA got %0h want 0", etc_inA); end
      rst = 1'b0; req_valid = 1'b0;
      tick();
      checks++; if (etc_op !== 4'd0) begin errors++; $display("FAIL rst_no_accept etc_op got %0d want 0", etc_op); end
   endtask

   task automatic test_single();
      int n;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 4'd1; req_a = ident(); req_b = fill_in(12'd5);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL single_ready got %0b want 1", req_ready); end
      tick();
      req_valid = 1'b0;
      checks++; if (etc_op !== 4'd1) begin errors++; $display("FAIL single_etc_op got %0d want 1", etc_op); end
      checks++; if (etc_inB !== fill_in(12'd5)) begin errors++; $display("FAIL single_etc_inB got %0h want all 5", etc_inB); end
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
      checks++; if (n !== LATENCY) begin errors++; $display("FAIL single_latency got %0d want %0d", n, LATENCY); end
      checks++; if (rsp_op !== 4'd1) begin errors++; $display("FAIL single_rsp_op got %0d want 1", rsp_op); end
      checks++; if (rsp_last !== 1'b1) begin errors++; $display("FAIL single_rsp_last got %0b want 1", rsp_last); end
      checks++; if (rsp_data !== fill_out(24'd5)) begin errors++; $display("FAIL single_rsp_data got %0h want all 5", rsp_data); end
      tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL single_drained got %0b want 0", rsp_valid); end
      checks++; if (etc_op !== 4'd0) begin errors++; $display("FAIL single_idle_op got %0d want 0", etc_op); end
   endtask

   task automatic test_back_to_back();
      logic [3:0] exp_op   [3];
      logic       exp_last [3];
      logic [23:0] exp_val [3];
      exp_op   = '{4'd3, 4'd3, 4'd1};
      exp_last = '{1'b0, 1'b1, 1'b1};
      exp_val  = '{24'd2, 24'd2, 24'd7};
      rsp_ready = 1'b0;
      req_valid = 1'b1; req_op = 4'd3; req_a = ident(); req_b = fill_in(12'd2);
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_op3 got %0b want 1", req_ready); end
      tick();
      req_op = 4'd1; req_b = fill_in(12'd7);
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL b2b_hold_ready got %0b want 0", req_ready); end
      checks++; if (etc_op !== 4'd3) begin errors++; $display("FAIL b2b_op_c1 got %0d want 3", etc_op); end
      tick();
      checks++; if (etc_op !== 4'd3) begin errors++; $display("FAIL b2b_op_c2 got %0d want 3", etc_op); end
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_after_hold got %0b want 1", req_ready); end
      tick();
      req_valid = 1'b0;
      checks++; if (etc_op !== 4'd1) begin errors++; $display("FAIL b2b_op_c3 got %0d want 1", etc_op); end
      tick(); tick();
      rsp_ready = 1'b1;
      for (int b = 0; b < 3; b++) begin
         checks++; if (rsp_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid[%0d] got %0b want 1", b, rsp_valid); end
         checks++; if (rsp_op !== exp_op[b]) begin errors++; $display("FAIL b2b_op[%0d] got %0d want %0d", b, rsp_op, exp_op[b]); end
         checks++; if (rsp_last !== exp_last[b]) begin errors++; $display("FAIL b2b_last[%0d] got %0b want %0b", b, rsp_last, exp_last[b]); end
         checks++; if (rsp_data !== fill_out(exp_val[b])) begin errors++; $display("FAIL b2b_data[%0d] got %0h want all %0d", b, rsp_data, exp_val[b]); end
         tick();
      end
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL b2b_drained got %0b want 0", rsp_valid); end
   endtask

   task automatic test_half();
      int n;
      mat_out_t exp;
      exp = fill_out(24'hFF8004);
      exp[2] = '0;
      exp[3] = '0;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 4'd2; req_a = fill_in(12'hFFF); req_b = fill_in(12'hFFF);
      tick();
      req_valid = 1'b0;
      n = 0;
      while (!rsp_valid && n < 10) begin tick(); n++; end
      checks++; if (rsp_op !== 4'd2) begin errors++; $display("FAIL half_op got %0d want 2", rsp_op); end
      checks++; if (rsp_data !== exp) begin errors++; $display("FAIL half_data got %0h want %0h", rsp_data, exp); end
      tick();
   endtask

   task automatic test_backpressure();
      int k;
      int r;
      int c;
      k = 0;
      r = 0;
      rsp_ready = 1'b0;
      for (int cy = 0; cy < 8; cy++) begin
         req_valid = 1'b1; req_op = 4'd0; req_a = fill_in(12'(k)); req_b = fill_in(12'd1);
         #1;
         if (req_ready) k++;
         tick();
      end
      req_a = fill_in(12'(k));
      #1;
      checks++; if (k !== DEPTH) begin errors++; $display("FAIL bp_accepted got %0d want %0d", k, DEPTH); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %0b want 0", req_ready); end
      rsp_ready = 1'b1;
      c = 0;
      while (r < 8 && c < 60) begin
         req_valid = (k < 8); req_op = 4'd0; req_a = fill_in(12'(k)); req_b = fill_in(12'd1);
         #1;
         if (rsp_valid) begin
            checks++;
            if (rsp_data !== fill_out(24'(r + 1)) || rsp_op !== 4'd0) begin
               errors++; $display("FAIL bp_beat[%0d] got op %0d data %0h want op 0 all %0d", r, rsp_op, rsp_data, r + 1);
            end
            r++;
         end
         if (req_valid && req_ready) k++;
         tick();
         c++;
      end
      req_valid = 1'b0;
      checks++; if (r !== 8) begin errors++; $display("FAIL bp_beats_returned got %0d want 8", r); end
      checks++; if (k !== 8) begin errors++; $display("FAIL bp_requests_taken got %0d want 8", k); end
   endtask

   task automatic test_credit_edge();
      rsp_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         req_valid = 1'b1; req_op = 4'd1; req_a = ident(); req_b = fill_in(12'(i + 1));
         tick();
      end
      req_valid = 1'b0;
      tick(); tick(); tick();
      req_valid = 1'b1; req_op = 4'd3;
      #1;
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL credit_op3 got %0b want 0", req_ready); end
      req_op = 4'd1;
      #1;
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL credit_op1 got %0b want 1", req_ready); end
      req_valid = 1'b0;
      #1;
      rsp_ready = 1'b1;
      tick(); tick(); tick();
      checks++; if (rsp_valid !== 1'b0) begin errors++; $display("FAIL credit_drained got %0b want 0", rsp_valid); end
   endtask

   task automatic test_reset_mid();
      logic seen;
      rsp_ready = 1'b1;
      req_valid = 1'b1; req_op = 4'd3; req_a = ident(); req_b = fill_in(12'd2);
      tick();
      req_valid = 1'b0;
      rst = 1'b1;
      tick();
      checks++; if (etc_op !== 4'd0) begin errors++; $display("FAIL rmid_etc_op got %0d want 0", etc_op); end
      checks++; if (etc_inA !== '0 || etc_inB !== '0) begin errors++; $display("FAIL rmid_etc_in got %0h want 0", etc_inA); end
      checks++; if (req_ready !== 1'b0) begin errors++; $display("FAIL rmid_ready got %0b want 0", req_ready); end
      checks++; if (rsp_valid !== 1'b0 || rsp_op !== 4'd0 || rsp_last !== 1'b0 || rsp_data !== '0) begin
         errors++; $display("FAIL rmid_rsp got valid %0b op %0d last %0b want all 0", rsp_valid, rsp_op, rsp_last);
      end
      rst = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (rsp_valid) seen = 1'b1;
      end
      checks++; if (seen !== 1'b0) begin errors++; $display("FAIL rmid_ghost_beat got %0b want 0", seen); end
      test_single();
   endtask

   initial begin
      errors = 0;
      checks = 0;
      rst = 1'b1;
      req_valid = 1'b0;
      req_op = 4'd0;
      req_a = '0;
      req_b = '0;
      rsp_ready = 1'b0;
      test_reset();
      test_single();
      test_back_to_back();
      test_half();
      test_backpressure();
      test_credit_edge();
      test_reset_mid();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end

endmodule
